// File: rtl/grf_pkg.sv
// grf_pkg: shared defaults and constants for the scoreboarded register file.
package grf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREAD_DEF  = 2;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/grf_bypass_port.sv
// grf_bypass_port: one read port with array select, write bypass and busy masking.
module grf_bypass_port
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] mem,
    input  logic [2**ADDR_W-1:0]             busy,
    input  logic [ADDR_W-1:0]                addr,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             iss_en,
    input  logic [ADDR_W-1:0]                iss_addr,
    output logic [DATA_W-1:0]                data,
    output logic                             pending
);
    logic live, hit;
    // A register being written reads the new value and is only busy if re-claimed now.
    always_comb begin
        live    = addr != ADDR_W'(ZERO_REG);
        hit     = live && wr_en && wr_addr == addr;
        data    = hit ? wr_data : live ? mem[addr] : '0;
        pending = live && (hit ? (iss_en && iss_addr == addr) : busy[addr]);
    end
endmodule

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: flop register file with per-register busy scoreboard and busy count.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = NREAD_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    writable,
    input  logic [ADDR_W-1:0]       writeAddr,
    input  logic [DATA_W-1:0]       writeData,
    input  logic [NREAD*ADDR_W-1:0] readAddr,
    output logic [NREAD*DATA_W-1:0] readData,
    input  logic                    issueValid,
    input  logic [ADDR_W-1:0]       issueAddr,
    output logic [NREAD-1:0]        readBusy,
    output logic [ADDR_W:0]         busyCount
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic [ADDR_W:0]              count;
    logic                         wr, iss, inc, dec;
    // Count tracks the busy vector: a same-register issue+write keeps the bit set.
    always_comb begin
        wr  = writable && writeAddr != ADDR_W'(ZERO_REG);
        iss = issueValid && issueAddr != ADDR_W'(ZERO_REG);
        inc = iss && !busy[issueAddr];
        dec = wr && busy[writeAddr] && !(iss && issueAddr == writeAddr);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem   <= '0;
            busy  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[writeAddr]  <= writeData;
                busy[writeAddr] <= 1'b0;
            end
            if (iss) busy[issueAddr] <= 1'b1;
            count <= count + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
        end
    end
    assign busyCount = count;
    for (genvar i = 0; i < NREAD; i++) begin : g_port
        grf_bypass_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
            .mem     (mem),
            .busy    (busy),
            .addr    (readAddr[i*ADDR_W +: ADDR_W]),
            .wr_en   (wr),
            .wr_addr (writeAddr),
            .wr_data (writeData),
            .iss_en  (iss),
            .iss_addr(issueAddr),
            .data    (readData[i*DATA_W +: DATA_W]),
            .pending (readBusy[i])
        );
    end
endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: directed and random checks of grf_scoreboard against an array model.
module tb_grf_scoreboard;
    localparam int DW = 32, AW = 5, NR = 2, D = 32;
    logic clk = 0, reset = 0, writable = 0, issueValid = 0;
    logic [AW-1:0] writeAddr = '0, issueAddr = '0;
    logic [DW-1:0] writeData = '0;
    logic [NR*AW-1:0] readAddr = '0;
    logic [NR*DW-1:0] readData, pre_data;
    logic [NR-1:0] readBusy, pre_busy;
    logic [AW:0] busyCount;
    logic [DW-1:0] m_mem [D];
    bit m_busy [D];
    bit armed = 0;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    grf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .clk(clk), .reset(reset), .writable(writable), .writeAddr(writeAddr),
        .writeData(writeData), .readAddr(readAddr), .readData(readData),
        .issueValid(issueValid), .issueAddr(issueAddr), .readBusy(readBusy),
        .busyCount(busyCount)
    );

    function automatic int popcount();
        int c = 0;
        foreach (m_busy[k]) c += int'(m_busy[k]);
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, check combinational outputs vs model, clock, check count.
    task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic eb;
        reset = rst; writable = we; writeAddr = wa; writeData = wd;
        issueValid = ie; issueAddr = ia; readAddr = {r1, r0};
        #1;
        pre_data = readData;
        pre_busy = readBusy;
        if (armed) begin
            for (int p = 0; p < NR; p++) begin
                a  = readAddr[p*AW +: AW];
                ed = (a == 0) ? '0 : (we && wa == a) ? wd : m_mem[a];
                eb = (a == 0) ? 1'b0 : (we && wa == a) ? (ie && ia == a) : m_busy[a];
                check($sformatf("rdata%0d@%0d", p, a), 64'(readData[p*DW +: DW]), 64'(ed));
                check($sformatf("rbusy%0d@%0d", p, a), 64'(readBusy[p]), 64'(eb));
            end
        end
        @(posedge clk);
        if (rst) begin
            foreach (m_mem[k]) begin m_mem[k] = '0; m_busy[k] = 0; end
        end else begin
            if (we && wa != 0) begin m_mem[wa] = wd; m_busy[wa] = 0; end
            if (ie && ia != 0) m_busy[ia] = 1;
        end
        #1;
        if (armed) check("busyCount", 64'(busyCount), 64'(popcount()));
    endtask

    task automatic peek(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        drive(0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    initial begin
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        armed = 1;
        check("reset_count", 64'(busyCount), 64'd0);
        for (int a = 0; a < D; a++) begin
            peek(AW'(a), AW'(D - 1 - a));
            check("reset_rd0", 64'(pre_data[DW-1:0]), 64'd0);
            check("reset_rd1", 64'(pre_data[2*DW-1:DW]), 64'd0);
            check("reset_busy", 64'(pre_busy), 64'd0);
        end
        drive(0, 1, 5, 32'h12345678, 0, 0, 5, 0);
        check("bypass5", 64'(pre_data[DW-1:0]), 64'h12345678);
        peek(5, 5);
        check("held5", 64'(pre_data[DW-1:0]), 64'h12345678);
        check("dup5", 64'(pre_data[2*DW-1:DW]), 64'h12345678);
        drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        check("zero_bypass", 64'(pre_data[DW-1:0]), 64'd0);
        check("zero_count", 64'(busyCount), 64'd0);
        peek(0, 0);
        check("zero_read", 64'(pre_data[DW-1:0]), 64'd0);
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 1, 7, 0, 0);
        check("cnt_two", 64'(busyCount), 64'd2);
        peek(3, 7);
        check("busy_3_7", 64'(pre_busy), 64'b11);
        drive(0, 1, 3, 32'h33, 0, 0, 3, 7);
        check("mask3", 64'(pre_busy), 64'b10);
        check("cnt_one", 64'(busyCount), 64'd1);
        drive(0, 1, 7, 32'h77, 1, 7, 7, 3);
        check("set_wins_pre", 64'(pre_busy), 64'b01);
        check("cnt_still_one", 64'(busyCount), 64'd1);
        peek(7, 3);
        check("busy7_after", 64'(pre_busy), 64'b01);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 1; a < D; a++) drive(0, 0, 0, 0, 1, AW'(a), AW'(a), 0);
        check("cnt_full", 64'(busyCount), 64'd31);
        drive(0, 0, 0, 0, 1, 4, 4, 0);
        check("cnt_reissue", 64'(busyCount), 64'd31);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 9, 32'hA5A5A5A5, 0, 0, 9, 0);
        drive(0, 0, 0, 0, 1, 9, 9, 9);
        peek(9, 9);
        check("r9_data", 64'(pre_data[DW-1:0]), 64'hA5A5A5A5);
        check("r9_busy", 64'(pre_busy), 64'b11);
        drive(1, 1, 9, 32'h1, 1, 9, 9, 0);
        check("rst_count", 64'(busyCount), 64'd0);
        peek(9, 9);
        check("rst_r9", 64'(pre_data[DW-1:0]), 64'd0);
        check("rst_busy9", 64'(pre_busy), 64'd0);
        drive(0, 1, 12, 32'hCAFE, 0, 0, 0, 0);
        peek(12, 0);
        check("first_write", 64'(pre_data[DW-1:0]), 64'hCAFE);
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] wa, ia, r0, r1;
            wa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ia = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? r0 : AW'($urandom);
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1, wa, DW'($urandom),
                  $urandom_range(0, 2) != 0, ia, r0, r1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
